// File: rtl/bsram_be_pipelined_if.sv
// Request/response bundle for the byte-enabled pipelined BSRAM.
// The master issues reads and writes; the memory returns readData/readValid and ready.
interface bsram_be_pipelined_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                      readEnable;
    logic [ADDR_WIDTH-1:0]     readAddress;
    logic [DATA_WIDTH-1:0]     readData;
    logic                      readValid;
    logic                      writeEnable;
    logic [ADDR_WIDTH-1:0]     writeAddress;
    logic [DATA_WIDTH-1:0]     writeData;
    logic [DATA_WIDTH/8-1:0]   writeByteEnable;
    logic                      ready;
    logic                      report;

    modport master (
        output readEnable, readAddress, writeEnable, writeAddress,
               writeData, writeByteEnable, report,
        input  readData, readValid, ready
    );

    modport slave (
        input  readEnable, readAddress, writeEnable, writeAddress,
               writeData, writeByteEnable, report,
        output readData, readValid, ready
    );
endinterface

// File: rtl/bsram_be_pipelined.sv
// Word-addressed SRAM with per-byte write enables, a 1- or 2-cycle registered read
// path with a readValid strobe, and an optional clear sweep after reset.
module bsram_be_pipelined #(
    parameter int CORE           = 0,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic                 clock,
    input logic                 reset,
    bsram_be_pipelined_if.slave bus
);
    localparam int MEM_DEPTH = 1 << ADDR_WIDTH;
    localparam int BYTES     = DATA_WIDTH / 8;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                  state;
    state_t                  stateNext;
    logic [ADDR_WIDTH-1:0]   clearAddr;
    logic                    readyQ;
    logic [DATA_WIDTH-1:0]   sram [MEM_DEPTH];
    logic                    readAccept;
    logic                    writeAccept;
    logic [DATA_WIDTH-1:0]   readWord;
    logic                    stageValid;
    logic [DATA_WIDTH-1:0]   stageData;
    logic                    readValidQ;
    logic [DATA_WIDTH-1:0]   readDataQ;

    if ((DATA_WIDTH % 8) != 0 || (READ_LATENCY != 1 && READ_LATENCY != 2) || CORE < 0) begin : gBadParams
        $error("bsram_be_pipelined core %0d: illegal DATA_WIDTH or READ_LATENCY", CORE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clearAddr <= '0;
            readyQ    <= 1'b0;
        end else begin
            state  <= stateNext;
            readyQ <= (stateNext == READY);
            if (state == CLEAR) begin
                clearAddr <= clearAddr + 1'b1;
            end
        end
    end

    // The sweep ends on the cycle that clears the top address.
    always_comb begin
        stateNext = state;
        if (state == CLEAR && (&clearAddr)) begin
            stateNext = READY;
        end
    end

    assign readAccept  = readyQ && !reset && bus.readEnable;
    assign writeAccept = readyQ && !reset && bus.writeEnable;

    // Write-first: a same-cycle write to the read address forwards its enabled bytes.
    always_comb begin
        readWord = sram[bus.readAddress];
        if (writeAccept && bus.writeAddress == bus.readAddress) begin
            for (int b = 0; b < BYTES; b++) begin
                if (bus.writeByteEnable[b]) begin
                    readWord[8*b +: 8] = bus.writeData[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == CLEAR) begin
                sram[clearAddr] <= '0;
            end else if (writeAccept) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (bus.writeByteEnable[b]) begin
                        sram[bus.writeAddress][8*b +: 8] <= bus.writeData[8*b +: 8];
                    end
                end
            end
        end
    end

    if (READ_LATENCY == 2) begin : gTwoStage
        always_ff @(posedge clock) begin
            if (reset) begin
                stageValid <= 1'b0;
                stageData  <= '0;
            end else begin
                stageValid <= readAccept;
                stageData  <= readWord;
            end
        end
    end else begin : gOneStage
        assign stageValid = readAccept;
        assign stageData  = readWord;
    end

    // Output register only loads on a valid result so readData holds between reads.
    always_ff @(posedge clock) begin
        if (reset) begin
            readValidQ <= 1'b0;
            readDataQ  <= '0;
        end else begin
            readValidQ <= stageValid;
            if (stageValid) begin
                readDataQ <= stageData;
            end
        end
    end

    assign bus.readValid = readValidQ;
    assign bus.readData  = readDataQ;
    assign bus.ready     = readyQ;
endmodule

// File: tb/tb_bsram_be_pipelined.sv
// Bench for bsram_be_pipelined: latency-1 and latency-2 instances share stimulus and a
// behavioural memory model; a third instance without the clear sweep is driven directly.
module tb_bsram_be_pipelined;
    localparam int DEPTH = 16;

    typedef struct {
        bit          valid;
        logic [31:0] data;
    } resp_t;

    logic clock = 1'b0;
    logic resetAB;
    logic resetC;

    always #5 clock = ~clock;

    bsram_be_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) busA (), busB (), busC ();

    bsram_be_pipelined #(.CORE(0), .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1))
        dutA (.clock(clock), .reset(resetAB), .bus(busA));
    bsram_be_pipelined #(.CORE(1), .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1))
        dutB (.clock(clock), .reset(resetAB), .bus(busB));
    bsram_be_pipelined #(.CORE(2), .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .CLEAR_ON_RESET(0))
        dutC (.clock(clock), .reset(resetC), .bus(busC));

    logic [31:0] model [DEPTH];
    bit          modelReady;
    int          clearCount;
    resp_t       pipeA[$];
    resp_t       pipeB[$];
    bit          expValidA, expValidB;
    logic [31:0] expDataA, expDataB;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Delay lines holding one response per cycle; a latency-L port starts with L-1 empty slots.
    task automatic flushPipes();
        pipeA = {};
        pipeB = {};
        pipeB.push_back('{1'b0, 32'h0});
        expValidA = 1'b0;
        expValidB = 1'b0;
        expDataA  = 32'h0;
        expDataB  = 32'h0;
    endtask

    task automatic applyStimulus(input bit rst, input bit re, input logic [3:0] ra, input bit we,
                                 input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] be);
        resp_t       r;
        logic [31:0] word;
        resetAB               = rst;
        busA.readEnable       = re;   busB.readEnable       = re;
        busA.readAddress      = ra;   busB.readAddress      = ra;
        busA.writeEnable      = we;   busB.writeEnable      = we;
        busA.writeAddress     = wa;   busB.writeAddress     = wa;
        busA.writeData        = wd;   busB.writeData        = wd;
        busA.writeByteEnable  = be;   busB.writeByteEnable  = be;
        busA.report           = 1'b0; busB.report           = 1'b0;
        @(posedge clock);
        if (rst) begin
            modelReady = 1'b0;
            clearCount = 0;
            flushPipes();
        end else begin
            word = model[ra];
            if (modelReady && we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        if (wa == ra) word[8*i +: 8] = wd[8*i +: 8];
                        model[wa][8*i +: 8] = wd[8*i +: 8];
                    end
                end
            end
            r.valid = modelReady && re;
            r.data  = word;
            pipeA.push_back(r);
            pipeB.push_back(r);
            r = pipeA.pop_front();
            expValidA = r.valid;
            if (r.valid) expDataA = r.data;
            r = pipeB.pop_front();
            expValidB = r.valid;
            if (r.valid) expDataB = r.data;
            if (!modelReady) begin
                clearCount++;
                if (clearCount == DEPTH) begin
                    modelReady = 1'b1;
                    foreach (model[i]) model[i] = 32'h0;
                end
            end
        end
        @(negedge clock);
        checkOutput("readyA", busA.ready, modelReady);
        checkOutput("readyB", busB.ready, modelReady);
        checkOutput("validA", busA.readValid, expValidA);
        checkOutput("dataA",  busA.readData,  expDataA);
        checkOutput("validB", busB.readValid, expValidB);
        checkOutput("dataB",  busB.readData,  expDataB);
    endtask

    initial begin
        resetC               = 1'b1;
        busC.readEnable      = 1'b0;
        busC.readAddress     = 4'd0;
        busC.writeEnable     = 1'b0;
        busC.writeAddress    = 4'd0;
        busC.writeData       = 32'h0;
        busC.writeByteEnable = 4'h0;
        busC.report          = 1'b0;
        flushPipes();

        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= DEPTH; k++) begin
            applyStimulus(0, 1, 4'(k), 1, 4'(k), 32'hFFFF_FFFF, 4'hF);
            checkOutput("clearLen", busA.ready, (k == DEPTH) ? 32'd1 : 32'd0);
        end

        // Fill with garbage, then reset: every word must read back as zero.
        for (int a = 0; a < DEPTH; a++) applyStimulus(0, 0, 0, 1, 4'(a), $urandom, 4'hF);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < DEPTH; k++) applyStimulus(0, 0, 0, 1, 4'(k), 32'hA5A5_5A5A, 4'hF);
        for (int a = 0; a < DEPTH; a++) applyStimulus(0, 1, 4'(a), 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        applyStimulus(0, 0, 0, 1, 4'd5, 32'hAABB_CCDD, 4'b1111);
        applyStimulus(0, 0, 0, 1, 4'd5, 32'h1122_3344, 4'b0101);
        applyStimulus(0, 1, 4'd5, 0, 0, 0, 0);
        checkOutput("beA", busA.readData, 32'hAA22_CC44);
        checkOutput("beValidA", busA.readValid, 32'd1);
        checkOutput("beEarlyB", busB.readValid, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("beB", busB.readData, 32'hAA22_CC44);
        checkOutput("beValidB", busB.readValid, 32'd1);

        applyStimulus(0, 0, 0, 1, 4'd7, 32'h0, 4'hF);
        applyStimulus(0, 1, 4'd7, 1, 4'd7, 32'hDEAD_BEEF, 4'b1100);
        checkOutput("collideA", busA.readData, 32'hDEAD_0000);
        applyStimulus(0, 0, 0, 1, 4'd7, 32'hFFFF_FFFF, 4'hF);
        checkOutput("collideB", busB.readData, 32'hDEAD_0000);
        checkOutput("collideHoldA", busA.readData, 32'hDEAD_0000);
        applyStimulus(0, 1, 4'd7, 0, 0, 0, 0);
        checkOutput("laterWriteA", busA.readData, 32'hFFFF_FFFF);

        for (int a = 1; a <= 3; a++) applyStimulus(0, 0, 0, 1, 4'(a), 32'(a), 4'hF);
        for (int a = 1; a <= 3; a++) applyStimulus(0, 1, 4'(a), 0, 0, 0, 0);
        checkOutput("pipeB1", busB.readData, 32'h2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("pipeB2", busB.readData, 32'h3);
        checkOutput("pipeValidB2", busB.readValid, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("pipeEndB", busB.readValid, 32'd0);

        // Reset with reads in flight in both pipelines.
        applyStimulus(0, 1, 4'd7, 0, 0, 0, 0);
        applyStimulus(1, 1, 4'd7, 0, 0, 0, 0);
        checkOutput("flushValidB", busB.readValid, 32'd0);
        checkOutput("flushDataA", busA.readData, 32'd0);
        for (int k = 0; k < 9; k++) applyStimulus(0, 1, 4'd7, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= DEPTH; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
            checkOutput("restartLen", busB.ready, (k == DEPTH) ? 32'd1 : 32'd0);
        end

        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(63) == 0, 1'($urandom), 4'($urandom), 1'($urandom),
                          4'($urandom), $urandom, 4'($urandom));
        end

        // Instance without the clear sweep: a read during reset is dropped.
        busC.readEnable  = 1'b1;
        busC.readAddress = 4'd3;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("cResetValid", busC.readValid, 32'd0);
        checkOutput("cResetReady", busC.ready, 32'd0);
        resetC               = 1'b0;
        busC.readEnable      = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("cReadyRise", busC.ready, 32'd1);
        busC.writeEnable     = 1'b1;
        busC.writeAddress    = 4'd3;
        busC.writeData       = 32'h1234_5678;
        busC.writeByteEnable = 4'hF;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        busC.writeEnable     = 1'b0;
        busC.readEnable      = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("cReadValid", busC.readValid, 32'd1);
        checkOutput("cReadData", busC.readData, 32'h1234_5678);
        resetC = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("cFlushValid", busC.readValid, 32'd0);
        checkOutput("cFlushData", busC.readData, 32'd0);
        resetC = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("cDropped", busC.readValid, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("cAfterReady", busC.readValid, 32'd1);
        checkOutput("cAfterReadyData", busC.readData, 32'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
